// File: rtl/ahb_lite_matrix_dec.sv
// AHB-lite single-master interconnect: parameterised address decode, data-phase mux,
// built-in default slave, wait-state watchdog and bus-fault capture.
module ahb_lite_matrix_dec #(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] BASE_ADDR      = {32'h4001_0000, 32'h4000_0000,
                                                          32'h2000_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0] ADDR_MASK      = {32'hFFFF_0000, 32'hFFFF_0000,
                                                          32'hFFFF_F000, 32'hFFFF_C000},
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic [31:0]                HADDR,
    input  logic [1:0]                 HTRANS,
    output logic                       HREADY,
    output logic [31:0]                HRDATA,
    output logic                       HRESP,
    output logic [NUM_SLAVES-1:0]      HSEL_S,
    input  logic [NUM_SLAVES-1:0]      HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]      HRESP_S,
    input  logic [32*NUM_SLAVES-1:0]   HRDATA_S,
    output logic                       ERR_IRQ,
    output logic [1:0]                 ERR_SRC,
    output logic [31:0]                ERR_ADDR
);

    localparam int IDXW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;
    typedef enum logic [1:0] {T_IDLE, T_ERR1, T_ERR2} tstate_t;

    dstate_t           dstate_q, dstate_d;
    tstate_t           tstate_q, tstate_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dp_vld_q;
    logic [IDXW-1:0]   dp_idx_q;
    logic [31:0]       dp_addr_q;
    logic              err_irq_q, err_irq_d;
    logic [1:0]        err_src_q, err_src_d;
    logic [31:0]       err_addr_q, err_addr_d;

    logic              match_any;
    logic [IDXW-1:0]   sel_idx;
    logic              dflt_req;
    logic              slv_rdy, slv_resp;
    logic [31:0]       slv_data;
    logic              hready, hresp;
    logic [31:0]       hrdata;
    logic              wd_hit;
    logic              unused_htrans;

    assign unused_htrans = HTRANS[0];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_any = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((HADDR & ADDR_MASK[32*i +: 32]) == BASE_ADDR[32*i +: 32]) begin
                match_any = 1'b1;
                sel_idx   = IDXW'(i);
            end
        end
        HSEL_S = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            HSEL_S[i] = match_any && (sel_idx == IDXW'(i));
        end
    end

    assign dflt_req = !match_any && HTRANS[1];

    always_comb begin
        slv_rdy  = 1'b1;
        slv_resp = 1'b0;
        slv_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dp_idx_q == IDXW'(i)) begin
                slv_rdy  = HREADYOUT_S[i];
                slv_resp = HRESP_S[i];
                slv_data = HRDATA_S[32*i +: 32];
            end
        end
    end

    assign wd_hit = WD_EN && (tstate_q == T_IDLE) && dp_vld_q && !slv_rdy && (cnt_q == CNT_LAST);

    always_comb begin
        dstate_d   = dstate_q;
        tstate_d   = tstate_q;
        cnt_d      = cnt_q;
        hready     = 1'b1;
        hresp      = 1'b0;
        hrdata     = '0;
        err_irq_d  = 1'b0;
        err_src_d  = err_src_q;
        err_addr_d = err_addr_q;

        // Error states override the slave; a slave ready on the expiry cycle beats the watchdog.
        if (dstate_q == D_ERR1 || tstate_q == T_ERR1) begin
            hready = 1'b0;
            hresp  = 1'b1;
        end else if (dstate_q == D_ERR2 || tstate_q == T_ERR2) begin
            hready = 1'b1;
            hresp  = 1'b1;
        end else if (dp_vld_q) begin
            hready = slv_rdy;
            hresp  = slv_resp;
            hrdata = slv_data;
        end

        case (dstate_q)
            D_IDLE:  if (dflt_req && hready) dstate_d = D_ERR1;
            D_ERR1:  dstate_d = D_ERR2;
            D_ERR2:  dstate_d = dflt_req ? D_ERR1 : D_IDLE;
            default: dstate_d = D_IDLE;
        endcase

        case (tstate_q)
            T_IDLE:  if (wd_hit) tstate_d = T_ERR1;
            T_ERR1:  tstate_d = T_ERR2;
            T_ERR2:  tstate_d = T_IDLE;
            default: tstate_d = T_IDLE;
        endcase

        if (hready) begin
            cnt_d = '0;
        end else if (WD_EN && tstate_q == T_IDLE && dp_vld_q && !slv_rdy && cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CW'(1);
        end

        if (dstate_q == D_ERR1) begin
            err_irq_d  = 1'b1;
            err_src_d  = 2'b01;
            err_addr_d = dp_addr_q;
        end else if (tstate_q == T_ERR1) begin
            err_irq_d  = 1'b1;
            err_src_d  = 2'b10;
            err_addr_d = dp_addr_q;
        end else if (tstate_q == T_IDLE && dp_vld_q && slv_resp && !slv_rdy) begin
            err_irq_d  = 1'b1;
            err_src_d  = 2'b11;
            err_addr_d = dp_addr_q;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dstate_q   <= D_IDLE;
            tstate_q   <= T_IDLE;
            cnt_q      <= '0;
            dp_vld_q   <= 1'b0;
            dp_idx_q   <= '0;
            dp_addr_q  <= '0;
            err_irq_q  <= 1'b0;
            err_src_q  <= '0;
            err_addr_q <= '0;
        end else begin
            dstate_q   <= dstate_d;
            tstate_q   <= tstate_d;
            cnt_q      <= cnt_d;
            err_irq_q  <= err_irq_d;
            err_src_q  <= err_src_d;
            err_addr_q <= err_addr_d;
            if (hready) begin
                dp_vld_q  <= HTRANS[1] && match_any;
                dp_idx_q  <= sel_idx;
                dp_addr_q <= HADDR;
            end
        end
    end

    assign HREADY   = hready;
    assign HRESP    = hresp;
    assign HRDATA   = hrdata;
    assign ERR_IRQ  = err_irq_q;
    assign ERR_SRC  = err_src_q;
    assign ERR_ADDR = err_addr_q;

endmodule

// File: tb/tb_ahb_lite_matrix_dec.sv
// Directed table-driven bench for ahb_lite_matrix_dec (4 slaves, 8-cycle watchdog).
module tb_ahb_lite_matrix_dec;

    logic         HCLK;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HREADY;
    logic [31:0]  HRDATA;
    logic         HRESP;
    logic [3:0]   HSEL_S;
    logic [3:0]   HREADYOUT_S;
    logic [3:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic         ERR_IRQ;
    logic [1:0]   ERR_SRC;
    logic [31:0]  ERR_ADDR;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;

    typedef struct {
        logic [31:0] haddr;
        logic [1:0]  htrans;
        logic [3:0]  rdy_s;
        logic [3:0]  rsp_s;
        logic [3:0]  sel;
        logic        hready;
        logic        hresp;
        logic [31:0] hrdata;
        logic        irq;
        logic [1:0]  src;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vq[$];

    ahb_lite_matrix_dec #(.TIMEOUT_CYCLES(8)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .HRESP       (HRESP),
        .HSEL_S      (HSEL_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .ERR_IRQ     (ERR_IRQ),
        .ERR_SRC     (ERR_SRC),
        .ERR_ADDR    (ERR_ADDR)
    );

    assign HRDATA_S = {32'h3333_3333, 32'h2222_2222, 32'hA5A5_5A5A, 32'h1111_0000};

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit exceeded");
    end

    function automatic vec_t mk(logic [31:0] a, logic [1:0] t, logic [3:0] r, logic [3:0] e,
                                logic [3:0] sel, logic rdy, logic rsp, logic [31:0] d,
                                logic irq, logic [1:0] src, logic [31:0] ea);
        vec_t v;
        v.haddr = a;   v.htrans = t;   v.rdy_s = r;  v.rsp_s = e;
        v.sel = sel;   v.hready = rdy; v.hresp = rsp; v.hrdata = d;
        v.irq = irq;   v.src = src;    v.eaddr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input int idx);
        chk("rst_hready", idx, 32'(HREADY), 32'd1);
        chk("rst_hresp", idx, 32'(HRESP), 32'd0);
        chk("rst_hrdata", idx, HRDATA, 32'd0);
        chk("rst_irq", idx, 32'(ERR_IRQ), 32'd0);
        chk("rst_src", idx, 32'(ERR_SRC), 32'd0);
        chk("rst_eaddr", idx, ERR_ADDR, 32'd0);
    endtask

    initial begin
        // zero-wait read of slave1
        vq.push_back(mk(32'h2000_0010, NS, 4'hF, 4'h0, 4'b0010, 1, 0, 32'h0, 0, 2'b00, 32'h0));
        vq.push_back(mk(32'h0000_0000, ID, 4'hF, 4'h0, 4'b0001, 1, 0, 32'hA5A5_5A5A, 0, 2'b00, 32'h0));
        // unmapped access: two-cycle ERROR, then an unmapped IDLE completes OKAY
        vq.push_back(mk(32'h3000_0000, NS, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0, 2'b00, 32'h0));
        vq.push_back(mk(32'h3000_0000, ID, 4'hF, 4'h0, 4'b0000, 0, 1, 32'h0, 0, 2'b00, 32'h0));
        vq.push_back(mk(32'h3000_0000, ID, 4'hF, 4'h0, 4'b0000, 1, 1, 32'h0, 1, 2'b01, 32'h3000_0000));
        vq.push_back(mk(32'h3000_0000, ID, 4'hF, 4'h0, 4'b0000, 1, 0, 32'h0, 0, 2'b01, 32'h3000_0000));
        // slave2 never ready: 8 waits then watchdog ERROR
        vq.push_back(mk(32'h4000_0004, NS, 4'hF, 4'h0, 4'b0100, 1, 0, 32'h0, 0, 2'b01, 32'h3000_0000));
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(32'h0, ID, 4'b1011, 4'h0, 4'b0001, 0, 0, 32'h2222_2222, 0, 2'b01, 32'h3000_0000));
        vq.push_back(mk(32'h0, ID, 4'b1011, 4'h0, 4'b0001, 0, 1, 32'h0, 0, 2'b01, 32'h3000_0000));
        vq.push_back(mk(32'h0, ID, 4'b1011, 4'h0, 4'b0001, 1, 1, 32'h0, 1, 2'b10, 32'h4000_0004));
        vq.push_back(mk(32'h0, ID, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0, 2'b10, 32'h4000_0004));
        // slave2 releases on the cycle the watchdog would expire
        vq.push_back(mk(32'h4000_0008, NS, 4'hF, 4'h0, 4'b0100, 1, 0, 32'h0, 0, 2'b10, 32'h4000_0004));
        for (int i = 0; i < 7; i++)
            vq.push_back(mk(32'h0, ID, 4'b1011, 4'h0, 4'b0001, 0, 0, 32'h2222_2222, 0, 2'b10, 32'h4000_0004));
        vq.push_back(mk(32'h0, ID, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h2222_2222, 0, 2'b10, 32'h4000_0004));
        vq.push_back(mk(32'h0, ID, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0, 2'b10, 32'h4000_0004));
        // slave3 two-cycle ERROR response
        vq.push_back(mk(32'h4001_0020, NS, 4'hF, 4'h0, 4'b1000, 1, 0, 32'h0, 0, 2'b10, 32'h4000_0004));
        vq.push_back(mk(32'h0, ID, 4'b0111, 4'b1000, 4'b0001, 0, 1, 32'h3333_3333, 0, 2'b10, 32'h4000_0004));
        vq.push_back(mk(32'h0, ID, 4'hF, 4'b1000, 4'b0001, 1, 1, 32'h3333_3333, 1, 2'b11, 32'h4001_0020));
        vq.push_back(mk(32'h0, ID, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0, 2'b11, 32'h4001_0020));
        // pipelined slave0 -> slave1 (2 waits) -> unmapped -> slave0
        vq.push_back(mk(32'h0000_0100, NS, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h0, 0, 2'b11, 32'h4001_0020));
        vq.push_back(mk(32'h2000_0004, NS, 4'hF, 4'h0, 4'b0010, 1, 0, 32'h1111_0000, 0, 2'b11, 32'h4001_0020));
        vq.push_back(mk(32'h3000_0010, NS, 4'b1101, 4'h0, 4'b0000, 0, 0, 32'hA5A5_5A5A, 0, 2'b11, 32'h4001_0020));
        vq.push_back(mk(32'h3000_0010, NS, 4'b1101, 4'h0, 4'b0000, 0, 0, 32'hA5A5_5A5A, 0, 2'b11, 32'h4001_0020));
        vq.push_back(mk(32'h3000_0010, NS, 4'hF, 4'h0, 4'b0000, 1, 0, 32'hA5A5_5A5A, 0, 2'b11, 32'h4001_0020));
        vq.push_back(mk(32'h0000_0200, NS, 4'hF, 4'h0, 4'b0001, 0, 1, 32'h0, 0, 2'b11, 32'h4001_0020));
        vq.push_back(mk(32'h0000_0200, NS, 4'hF, 4'h0, 4'b0001, 1, 1, 32'h0, 1, 2'b01, 32'h3000_0010));
        vq.push_back(mk(32'h0, ID, 4'hF, 4'h0, 4'b0001, 1, 0, 32'h1111_0000, 0, 2'b01, 32'h3000_0010));

        HRESETn = 1'b0;
        HADDR = 32'h0;
        HTRANS = ID;
        HREADYOUT_S = 4'hF;
        HRESP_S = 4'h0;
        #12;
        chk_reset_outs(-1);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;

        foreach (vq[k]) begin
            @(posedge HCLK); #1;
            HADDR = vq[k].haddr;
            HTRANS = vq[k].htrans;
            HREADYOUT_S = vq[k].rdy_s;
            HRESP_S = vq[k].rsp_s;
            #4;
            chk("hsel", k, 32'(HSEL_S), 32'(vq[k].sel));
            chk("hready", k, 32'(HREADY), 32'(vq[k].hready));
            chk("hresp", k, 32'(HRESP), 32'(vq[k].hresp));
            chk("hrdata", k, HRDATA, vq[k].hrdata);
            chk("err_irq", k, 32'(ERR_IRQ), 32'(vq[k].irq));
            chk("err_src", k, 32'(ERR_SRC), 32'(vq[k].src));
            chk("err_addr", k, ERR_ADDR, vq[k].eaddr);
        end

        // reset asserted while the default slave sits in its first ERROR cycle
        @(posedge HCLK); #1;
        HADDR = 32'h3000_0000;
        HTRANS = NS;
        HREADYOUT_S = 4'hF;
        HRESP_S = 4'h0;
        #4;
        chk("rstseq_addr_hready", 100, 32'(HREADY), 32'd1);
        @(posedge HCLK); #1;
        HTRANS = ID;
        #4;
        chk("rstseq_err1_hready", 101, 32'(HREADY), 32'd0);
        chk("rstseq_err1_hresp", 101, 32'(HRESP), 32'd1);
        HRESETn = 1'b0;
        #1;
        chk_reset_outs(102);
        @(posedge HCLK); #4;
        chk_reset_outs(103);
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge HCLK); #4;
            chk_reset_outs(104 + i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
